// File: rtl/if_id_instr_buffer.sv
// IF/ID instruction buffer: a small FIFO between fetch and decode. Fetched
// {pc, instr} words are queued, and the head entry is presented already split
// into opcode/rd/rs1/imm17, together with the extension select for the
// immediate extender. A flush from a taken branch/jump discards every entry.
module if_id_instr_buffer #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               out_opcode,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [16:0]              imm17,
  output logic                     SIG_ExtOp,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PtrW   = $clog2(DEPTH);
  localparam int CntW   = PtrW + 1;
  localparam int EntryW = PC_W + 32;

  logic [EntryW-1:0] storage [DEPTH];
  logic [PtrW-1:0]   wrPtr;
  logic [PtrW-1:0]   rdPtr;
  logic [CntW-1:0]   occupancy;
  logic              pushEn;
  logic              popEn;
  logic [EntryW-1:0] headEntry;
  logic [31:0]       headInstr;

  // Handshake flags come straight from the registered occupancy, so a pop on
  // a full buffer cannot open in_ready in the same cycle; a flush cancels both.
  always_comb begin
    in_ready  = (occupancy != CntW'(DEPTH));
    out_valid = (occupancy != '0);
    pushEn    = in_valid & in_ready & ~flush;
    popEn     = out_valid & out_ready & ~flush;
  end

  // Entry storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      storage[wrPtr] <= {in_pc, in_instr};
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (pushEn) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      case ({pushEn, popEn})
        2'b10:   occupancy <= occupancy + CntW'(1);
        2'b01:   occupancy <= occupancy - CntW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Head fields are a pure function of the entry under the read pointer; the
  // logical-immediate opcode group (opcode[4:3] == 01) takes zero extension.
  always_comb begin
    headEntry  = storage[rdPtr];
    headInstr  = headEntry[31:0];
    out_pc     = headEntry[EntryW-1:32];
    out_opcode = headInstr[31:27];
    out_rd     = headInstr[26:22];
    out_rs1    = headInstr[21:17];
    imm17      = headInstr[16:0];
    SIG_ExtOp  = (headInstr[31:30] != 2'b01);
    count      = occupancy;
  end

endmodule

// File: tb/tb_if_id_instr_buffer.sv
// Directed testbench for the IF/ID instruction buffer (DEPTH=2, PC_W=32).
module tb_if_id_instr_buffer;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [4:0]        out_opcode;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [16:0]       imm17;
  logic              SIG_ExtOp;
  logic [1:0]        count;

  int errors = 0;
  int checks = 0;

  if_id_instr_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .imm17      (imm17),
    .SIG_ExtOp  (SIG_ExtOp),
    .count      (count)
  );

  // Free-running 10 ns clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive every input at once.
  task automatic setInputs(input logic valid, input logic [31:0] pc,
                           input logic [31:0] instr, input logic ready,
                           input logic fl);
    in_valid  = valid;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = ready;
    flush     = fl;
  endtask

  // Drive inputs, then advance one rising edge and settle 1 ns past it.
  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic [31:0] instr, input logic ready,
                               input logic fl);
    setInputs(valid, pc, instr, ready, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    setInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset count", 64'(count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Push into empty: nothing visible before the edge, head after it.
    setInputs(1'b1, 32'h100, 32'h0842_FFFF, 1'b0, 1'b0);
    #1;
    checkOutput("no bypass out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    setInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("push1 out_valid", 64'(out_valid), 64'd1);
    checkOutput("push1 count", 64'(count), 64'd1);
    checkOutput("push1 opcode", 64'(out_opcode), 64'h01);
    checkOutput("push1 rd", 64'(out_rd), 64'h01);
    checkOutput("push1 rs1", 64'(out_rs1), 64'h01);
    checkOutput("push1 imm17", 64'(imm17), 64'h0FFFF);
    checkOutput("push1 extop", 64'(SIG_ExtOp), 64'd1);
    checkOutput("push1 pc", 64'(out_pc), 64'h100);

    // Pop it.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("pop1 count", 64'(count), 64'd0);
    checkOutput("pop1 out_valid", 64'(out_valid), 64'd0);

    // Sign-extended immediate with all 17 bits set.
    applyStimulus(1'b1, 32'h0F0, 32'h0843_FFFF, 1'b0, 1'b0);
    checkOutput("imm all ones", 64'(imm17), 64'h1FFFF);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Logical-immediate opcode: zero extension.
    applyStimulus(1'b1, 32'h104, 32'h5000_0005, 1'b0, 1'b0);
    checkOutput("logic opcode", 64'(out_opcode), 64'h0A);
    checkOutput("logic extop", 64'(SIG_ExtOp), 64'd0);
    checkOutput("logic imm17", 64'(imm17), 64'h00005);
    checkOutput("logic rd", 64'(out_rd), 64'h00);

    // Stalled head stays stable.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall pc", 64'(out_pc), 64'h104);
    checkOutput("stall imm17", 64'(imm17), 64'h00005);

    // Fill to DEPTH.
    applyStimulus(1'b1, 32'h108, 32'h8FFE_0003, 1'b0, 1'b0);
    checkOutput("full count", 64'(count), 64'd2);
    checkOutput("full in_ready", 64'(in_ready), 64'd0);
    checkOutput("full head pc", 64'(out_pc), 64'h104);

    // Offer while full: ignored.
    applyStimulus(1'b1, 32'h10C, 32'h1111_1111, 1'b0, 1'b0);
    checkOutput("ignored count", 64'(count), 64'd2);

    // Pop while full with a word offered: in_ready must stay low.
    setInputs(1'b1, 32'h10C, 32'h1111_1111, 1'b1, 1'b0);
    #1;
    checkOutput("full pop in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("drain1 count", 64'(count), 64'd1);
    checkOutput("drain1 pc", 64'(out_pc), 64'h108);
    checkOutput("drain1 opcode", 64'(out_opcode), 64'h11);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain2 count", 64'(count), 64'd0);
    checkOutput("drain2 out_valid", 64'(out_valid), 64'd0);

    // Streaming: one push and one pop per cycle, pointers wrap repeatedly.
    applyStimulus(1'b1, 32'h200, 32'h200, 1'b1, 1'b0);
    checkOutput("stream start count", 64'(count), 64'd1);
    for (int k = 0; k < 20; k++) begin
      logic [31:0] pc;
      pc = 32'h204 + 32'(4 * k);
      applyStimulus(1'b1, pc, pc, 1'b1, 1'b0);
      checkOutput($sformatf("stream%0d count", k), 64'(count), 64'd1);
      checkOutput($sformatf("stream%0d pc", k), 64'(out_pc), 64'(pc));
      checkOutput($sformatf("stream%0d imm17", k), 64'(imm17), 64'(pc[16:0]));
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("stream end count", 64'(count), 64'd0);

    // Flush a full buffer with a word on offer.
    applyStimulus(1'b1, 32'h300, 32'h300, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h304, 32'h304, 1'b0, 1'b0);
    checkOutput("preflush count", 64'(count), 64'd2);
    applyStimulus(1'b1, 32'h308, 32'h308, 1'b0, 1'b1);
    checkOutput("flush full count", 64'(count), 64'd0);
    checkOutput("flush full out_valid", 64'(out_valid), 64'd0);

    // Flush while a push and pop would both fire: the offered word is dropped.
    applyStimulus(1'b1, 32'h400, 32'h400, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h404, 32'h404, 1'b1, 1'b1);
    checkOutput("flush push count", 64'(count), 64'd0);
    applyStimulus(1'b1, 32'h500, 32'h500, 1'b0, 1'b0);
    checkOutput("post flush count", 64'(count), 64'd1);
    checkOutput("post flush pc", 64'(out_pc), 64'h500);

    // Asynchronous reset mid-cycle while holding two words.
    applyStimulus(1'b1, 32'h504, 32'h504, 1'b0, 1'b0);
    setInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst count", 64'(count), 64'd0);
    checkOutput("async rst out_valid", 64'(out_valid), 64'd0);
    checkOutput("async rst in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h600, 32'h600, 1'b0, 1'b0);
    checkOutput("after rst count", 64'(count), 64'd1);
    checkOutput("after rst pc", 64'(out_pc), 64'h600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
